// File: rtl/ahb_input_stage_s0.sv
// AHB bus-matrix input stage for slave port S0: forwards the master's address phase, holds it
// while the addressed output stage is busy, and returns the data-phase ready/response.
module ahb_input_stage_s0 #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              active_dec,
    input  logic              readyout_dec,
    input  logic [1:0]        resp_dec,
    output logic              sel_in,
    output logic [ADDR_W-1:0] addr_in,
    output logic [1:0]        trans_in,
    output logic              write_in,
    output logic [2:0]        size_in,
    output logic [2:0]        burst_in,
    output logic [3:0]        prot_in,
    output logic              mastlock_in,
    output logic              ready_in,
    output logic              held_tran,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS
);

    logic              w_new_req;
    logic              r_pend;
    logic              r_data;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_trans;
    logic              r_write;
    logic [2:0]        r_size;
    logic [2:0]        r_burst;
    logic [3:0]        r_prot;
    logic              r_mastlock;

    assign w_new_req = HSELS & HREADYS & HTRANSS[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_pend     <= 1'b0;
            r_data     <= 1'b0;
            r_addr     <= '0;
            r_trans    <= 2'b00;
            r_write    <= 1'b0;
            r_size     <= 3'b000;
            r_burst    <= 3'b000;
            r_prot     <= 4'b0000;
            r_mastlock <= 1'b0;
        end else if (!r_pend) begin
            if (w_new_req && !active_dec) begin
                // Output stage busy: park the address phase and stall the master.
                r_pend     <= 1'b1;
                r_data     <= 1'b0;
                r_addr     <= HADDRS;
                r_trans    <= HTRANSS;
                r_write    <= HWRITES;
                r_size     <= HSIZES;
                r_burst    <= HBURSTS;
                r_prot     <= HPROTS;
                r_mastlock <= HMASTLOCKS;
            end else if (w_new_req) begin
                r_data <= 1'b1;
            end else if (HREADYS) begin
                r_data <= 1'b0;
            end
        end else if (active_dec && readyout_dec) begin
            // Held address phase is accepted on this edge.
            r_pend <= 1'b0;
            r_data <= 1'b1;
        end
    end

    always_comb begin
        if (r_pend) begin
            sel_in      = 1'b1;
            addr_in     = r_addr;
            trans_in    = r_trans;
            write_in    = r_write;
            size_in     = r_size;
            burst_in    = r_burst;
            prot_in     = r_prot;
            mastlock_in = r_mastlock;
            ready_in    = readyout_dec;
        end else begin
            sel_in      = HSELS;
            addr_in     = HADDRS;
            trans_in    = HTRANSS;
            write_in    = HWRITES;
            size_in     = HSIZES;
            burst_in    = HBURSTS;
            prot_in     = HPROTS;
            mastlock_in = HMASTLOCKS;
            ready_in    = HREADYS;
        end
    end

    assign held_tran  = r_pend;
    assign HREADYOUTS = r_pend ? 1'b0 : (r_data ? readyout_dec : 1'b1);
    assign HRESPS     = (!r_pend && r_data) ? resp_dec : 2'b00;

endmodule

// File: tb/tb_ahb_input_stage_s0.sv
// Directed bench for ahb_input_stage_s0: expectations queued at drive time, popped at sample time.
module tb_ahb_input_stage_s0;

    localparam int unsigned ADDR_W = 32;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic              HSELS;
    logic [ADDR_W-1:0] HADDRS;
    logic [1:0]        HTRANSS;
    logic              HWRITES;
    logic [2:0]        HSIZES;
    logic [2:0]        HBURSTS;
    logic [3:0]        HPROTS;
    logic              HMASTLOCKS;
    logic              HREADYS;
    logic              active_dec;
    logic              readyout_dec;
    logic [1:0]        resp_dec;
    logic              sel_in;
    logic [ADDR_W-1:0] addr_in;
    logic [1:0]        trans_in;
    logic              write_in;
    logic [2:0]        size_in;
    logic [2:0]        burst_in;
    logic [3:0]        prot_in;
    logic              mastlock_in;
    logic              ready_in;
    logic              held_tran;
    logic              HREADYOUTS;
    logic [1:0]        HRESPS;

    ahb_input_stage_s0 #(.ADDR_W(ADDR_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
        .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
        .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .active_dec(active_dec),
        .readyout_dec(readyout_dec), .resp_dec(resp_dec), .sel_in(sel_in), .addr_in(addr_in),
        .trans_in(trans_in), .write_in(write_in), .size_in(size_in), .burst_in(burst_in),
        .prot_in(prot_in), .mastlock_in(mastlock_in), .ready_in(ready_in),
        .held_tran(held_tran), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void exp_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endfunction

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_underflow: observed %0h with no expected value queued", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESETn = 1'b0; HSELS = 1'b1; HADDRS = 32'h0; HTRANSS = 2'b10; HWRITES = 1'b0;
        HSIZES = 3'b0; HBURSTS = 3'b0; HPROTS = 4'b0; HMASTLOCKS = 1'b0; HREADYS = 1'b1;
        active_dec = 1'b0; readyout_dec = 1'b1; resp_dec = 2'b00;

        // Reset with a NONSEQ pending on the master side
        #22;
        exp_push("rst_held", 0); exp_push("rst_hready", 1); exp_push("rst_hresp", 0);
        chk(held_tran); chk(HREADYOUTS); chk(HRESPS);
        HTRANSS = 2'b00;
        HRESETn = 1'b1;
        HADDRS = 32'h1234_5678;
        #1;
        exp_push("rst_addr_track", 32'h1234_5678);
        chk(addr_in);

        // Pass-through with two wait states
        tick();
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h2000_0040; HWRITES = 1'b0;
        active_dec = 1'b1; readyout_dec = 1'b1; HREADYS = 1'b1;
        exp_push("pt_addr", 32'h2000_0040); exp_push("pt_sel", 1); exp_push("pt_trans", 2);
        exp_push("pt_held", 0); exp_push("pt_ready_in", 1);
        #1;
        chk(addr_in); chk(sel_in); chk(trans_in); chk(held_tran); chk(ready_in);
        tick();
        HTRANSS = 2'b00; readyout_dec = 1'b0; HREADYS = 1'b0;
        exp_push("pt_ws1", 0); exp_push("pt_ws1_held", 0);
        #1;
        chk(HREADYOUTS); chk(held_tran);
        tick();
        exp_push("pt_ws2", 0);
        #1;
        chk(HREADYOUTS);
        tick();
        readyout_dec = 1'b1; HREADYS = 1'b1;
        exp_push("pt_done", 1);
        #1;
        chk(HREADYOUTS);
        tick();
        readyout_dec = 1'b0;
        exp_push("pt_data_cleared", 1);
        #1;
        chk(HREADYOUTS);

        // Stall: master not ready and BUSY are never captured
        HSELS = 1'b1; HTRANSS = 2'b10; HREADYS = 1'b0; active_dec = 1'b0;
        tick();
        exp_push("nohready_nocap", 0);
        chk(held_tran);

        // Hold: write to 0x4000_0008 parked for three cycles
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h4000_0008; HWRITES = 1'b1; HSIZES = 3'b010;
        HREADYS = 1'b1; active_dec = 1'b0; readyout_dec = 1'b1;
        tick();
        HSELS = 1'b0; HTRANSS = 2'b00; HADDRS = 32'h0; HWRITES = 1'b0; HSIZES = 3'b000;
        HREADYS = 1'b0; resp_dec = 2'b01;
        exp_push("hold1_held", 1); exp_push("hold1_hready", 0); exp_push("hold1_addr", 32'h4000_0008);
        exp_push("hold1_write", 1); exp_push("hold1_size", 2); exp_push("hold1_sel", 1);
        exp_push("hold1_trans", 2); exp_push("hold1_ready_in", 1); exp_push("hold1_hresp", 0);
        #1;
        chk(held_tran); chk(HREADYOUTS); chk(addr_in); chk(write_in); chk(size_in);
        chk(sel_in); chk(trans_in); chk(ready_in); chk(HRESPS);
        resp_dec = 2'b00;
        tick();
        readyout_dec = 1'b0;
        exp_push("hold2_held", 1); exp_push("hold2_hready", 0); exp_push("hold2_addr", 32'h4000_0008);
        exp_push("hold2_write", 1); exp_push("hold2_ready_in", 0);
        #1;
        chk(held_tran); chk(HREADYOUTS); chk(addr_in); chk(write_in); chk(ready_in);
        tick();
        active_dec = 1'b1; readyout_dec = 1'b1;
        exp_push("hold3_held", 1); exp_push("hold3_hready", 0); exp_push("hold3_addr", 32'h4000_0008);
        #1;
        chk(held_tran); chk(HREADYOUTS); chk(addr_in);
        tick();
        readyout_dec = 1'b0;
        exp_push("rel_held", 0); exp_push("rel_hready_low", 0); exp_push("rel_sel_live", 0);
        exp_push("rel_addr_live", 0);
        #1;
        chk(held_tran); chk(HREADYOUTS); chk(sel_in); chk(addr_in);

        // Two-cycle ERROR response in the released data phase
        resp_dec = 2'b01;
        exp_push("err1_hresp", 1); exp_push("err1_hready", 0);
        #1;
        chk(HRESPS); chk(HREADYOUTS);
        tick();
        readyout_dec = 1'b1;
        exp_push("err2_hresp", 1); exp_push("err2_hready", 1);
        #1;
        chk(HRESPS); chk(HREADYOUTS);
        HREADYS = 1'b1;
        tick();
        resp_dec = 2'b00;

        // Reset while a transfer is held
        HSELS = 1'b1; HTRANSS = 2'b10; HADDRS = 32'h5000_0000; HREADYS = 1'b1; active_dec = 1'b0;
        tick();
        exp_push("rh_held_before", 1);
        #1;
        chk(held_tran);
        HRESETn = 1'b0;
        exp_push("rh_held_async", 0); exp_push("rh_hready_async", 1);
        #1;
        chk(held_tran); chk(HREADYOUTS);
        HSELS = 1'b0; HTRANSS = 2'b00; HADDRS = 32'h0000_0100; active_dec = 1'b1;
        readyout_dec = 1'b1;
        #1;
        HRESETn = 1'b1;
        tick();
        readyout_dec = 1'b0;
        exp_push("rh_after_held", 0); exp_push("rh_after_sel", 0);
        exp_push("rh_after_addr", 32'h0000_0100); exp_push("rh_after_hready", 1);
        #1;
        chk(held_tran); chk(sel_in); chk(addr_in); chk(HREADYOUTS);

        // BUSY with output stage unavailable
        HSELS = 1'b1; HTRANSS = 2'b01; HREADYS = 1'b1; active_dec = 1'b0; readyout_dec = 1'b1;
        exp_push("busy_sel", 1); exp_push("busy_trans", 1);
        #1;
        chk(sel_in); chk(trans_in);
        tick();
        exp_push("busy_held", 0); exp_push("busy_hready", 1);
        chk(held_tran); chk(HREADYOUTS);
        tick();
        exp_push("busy_held2", 0);
        chk(held_tran);

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_err++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_input_stage_s0.md
Name: ahb_input_stage_s0

Overview:
Slave-side input stage for bus-matrix port S0. It sits directly upstream of the S0 decoder stage and feeds it. It presents the master's address-phase controls to the decoder and output stages. When the decoder reports the target output stage is unavailable (active_dec=0), it captures the transfer in a holding register and stalls the master until the output stage accepts the held address phase. It also returns the data-phase HREADYOUTS/HRESPS to the master.

Parameters:
ADDR_W, 32, address width; must be 32, since the decoder consumes addr_in[31:10].

Ports:
HCLK  in  1  AHB system clock
HRESETn  in  1  asynchronous active-low reset
HSELS  in  1  master-side HSEL
HADDRS  in  ADDR_W  master-side HADDR
HTRANSS  in  2  master-side HTRANS
HWRITES  in  1  master-side HWRITE
HSIZES  in  3  master-side HSIZE
HBURSTS  in  3  master-side HBURST
HPROTS  in  4  master-side HPROT
HMASTLOCKS  in  1  master-side HMASTLOCK
HREADYS  in  1  master-side HREADY (bus ready)
active_dec  in  1  decoder: addressed output stage is granted to S0
readyout_dec  in  1  decoder: selected HREADYOUT
resp_dec  in  2  decoder: selected HRESP
sel_in  out  1  HSEL to decoder
addr_in  out  ADDR_W  HADDR to decoder/output stages
trans_in  out  2  HTRANS to decoder/output stages
write_in, size_in, burst_in, prot_in, mastlock_in  out  1/3/3/4/1  controls to output stages
ready_in  out  1  HREADY to decoder (decoder's HREADYS)
held_tran  out  1  holding register valid
HREADYOUTS  out  1  HREADYOUT to master
HRESPS  out  2  HRESP to master

Behaviour:
- Clocking and reset: HCLK with HRESETn asynchronous active-low. Reset clears pend_reg, data_reg and all holding registers to 0.
- Reset output values: held_tran=0, HREADYOUTS=1, HRESPS=2'b00. Address outputs pass HSELS/HADDRS/HTRANSS/etc. combinationally.
- Definition: new_req = HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ).
- State machine, two flag registers:
  - pend_reg: holding register valid.
  - data_reg: S0 owns a data phase on an output stage.
- IDLE state (pend_reg=0):
  - Outputs mux from live master signals: sel_in=HSELS, trans_in=HTRANSS, and so on; ready_in=HREADYS.
  - On new_req & ~active_dec: load the holding register (addr, trans, write, size, burst, prot, mastlock) and set pend_reg. Next state is PEND.
  - On new_req & active_dec: the transfer goes straight through, data_reg<=1, pend_reg stays 0.
  - On HREADYS & ~new_req: data_reg<=0.
- PEND state (pend_reg=1):
  - Outputs mux from the holding register: sel_in=1, trans_in=stored value (unchanged), ready_in=readyout_dec.
  - HREADYOUTS=0 and HRESPS=OKAY, so the master is stalled; master inputs are ignored.
  - At the clock edge where active_dec & readyout_dec: pend_reg<=0 and data_reg<=1. The held address phase completes the same edge; latency is 1 cycle minimum after capture.
  - If active_dec=1 but readyout_dec=0: remain in PEND.
- Data-phase return:
  - HREADYOUTS = pend_reg ? 0 : (data_reg ? readyout_dec : 1).
  - HRESPS = (~pend_reg & data_reg) ? resp_dec : 2'b00.
  - Two-cycle ERROR/RETRY/SPLIT responses pass through unmodified.
- Holding register: loads only on the capture edge; never reloads while pend_reg=1.
- BUSY/IDLE transfers (HTRANSS[1]=0) are never captured. They pass through with sel_in=HSELS.
- Simultaneous events: capture and release cannot coincide, because capture requires pend_reg=0. HRESETn assertion in PEND or mid data phase clears everything immediately, and no held transfer is issued after reset.
- No combinational path from HREADYOUTS to ready_in other than through readyout_dec.

Test Plan:
- Reset: hold HRESETn=0 with HSELS=1, HTRANSS=2'b10 -> held_tran=0, HREADYOUTS=1, HRESPS=00. After release, addr_in tracks HADDRS.
- Pass-through: NONSEQ to 0x2000_0040 with active_dec=1, readyout_dec=1 -> addr_in=0x2000_0040 same cycle, no capture. Next cycle HREADYOUTS follows readyout_dec; 2 wait states from readyout_dec give 2 low cycles.
- Hold: NONSEQ write to 0x4000_0008, HSIZES=010, with active_dec=0 for 3 cycles, then 1 with readyout_dec=1.
  - held_tran=1 and HREADYOUTS=0 for 3 cycles.
  - addr_in=0x4000_0008 and write_in=1 throughout while HADDRS changes to 0x0.
  - Release on the 4th edge.
  - Then HREADYOUTS=readyout_dec.
- Error: data phase with resp_dec=01 for 2 cycles (readyout_dec 0 then 1) -> HRESPS=01 both cycles, HREADYOUTS 0 then 1.
- Reset mid-hold: assert HRESETn=0 while held_tran=1 -> held_tran=0 asynchronously. After release sel_in=HSELS and no held transfer is issued.
- IDLE/BUSY: HTRANSS=01 with active_dec=0 -> no capture, held_tran stays 0, HREADYOUTS=1.
